// File: rtl/rx_uart_if.sv
// Receive-side bus of the UART receiver: the serial line in, the byte and
// status out, and the consumer read strobe back in.
interface rx_uart_if;
   logic       rx;
   logic       rx_rd;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   // The receiver owns the byte/status side and listens to the line and strobe.
   modport master (
      input  rx,
      input  rx_rd,
      output rx_data,
      output rx_ready,
      output frame_err,
      output overrun
   );

   // Line driver / byte consumer side.
   modport slave (
      output rx,
      output rx_rd,
      input  rx_data,
      input  rx_ready,
      input  frame_err,
      input  overrun
   );
endinterface

// File: rtl/rx_uart.sv
// UART receiver, 8N1, LSB first, idle-high line.
// The asynchronous rx line is synchronised, the start bit is confirmed at its
// mid-point, and every data bit and the stop bit are sampled at mid-bit.
// A good byte is held in rx_data behind a ready/read handshake. Framing and
// overrun errors are reported as single-cycle pulses.
module rx_uart #(
   parameter logic [9:0] DIV_CNT  = 10'd867,  // bit period minus 1, in clk cycles
   parameter logic [9:0] HDIV_CNT = 10'd433,  // half bit period minus 1
   parameter logic [3:0] RX_CNT   = 4'h8      // data bits per frame
) (
   input logic       clk,
   input logic       rst,
   rx_uart_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HI
   } state_t;

   state_t     state;
   logic [1:0] sync;
   logic       rx_s;
   logic [9:0] div_cnt;
   logic [3:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;

   assign rx_s = sync[1];

   // Two-flop synchroniser on the serial line; resets to the idle (high) level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= 2'b11;
      end else begin
         // NOTE: registered state uses non-blocking assignments so every flop
         // samples the values from before the clock edge, never a half-updated one.
         sync <= {sync[0], bus.rx};
      end
   end

   // Frame FSM with the byte hold register, ready handshake and error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         div_cnt   <= 10'd0;
         bit_cnt   <= 4'd0;
         shreg     <= 8'd0;
         rx_data   <= 8'd0;
         rx_ready  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         // A read clears ready; a byte completing in this same cycle overrides it below.
         if (bus.rx_rd && rx_ready) begin
            rx_ready <= 1'b0;
         end

         case (state)
            IDLE: begin
               div_cnt <= 10'd0;
               if (!rx_s) begin
                  state <= START;
               end
            end

            START: begin
               if (div_cnt == HDIV_CNT) begin
                  div_cnt <= 10'd0;
                  bit_cnt <= 4'd0;
                  // Line back high at mid start bit is a glitch: drop it silently.
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  div_cnt <= div_cnt + 10'd1;
               end
            end

            DATA: begin
               if (div_cnt == DIV_CNT) begin
                  div_cnt <= 10'd0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == RX_CNT - 4'd1) begin
                     state <= STOP;
                  end
               end else begin
                  div_cnt <= div_cnt + 10'd1;
               end
            end

            STOP: begin
               if (div_cnt == DIV_CNT) begin
                  div_cnt <= 10'd0;
                  if (rx_s) begin
                     // Leaving mid stop bit lets a back-to-back start edge be caught.
                     state <= IDLE;
                     if (!rx_ready || bus.rx_rd) begin
                        rx_data  <= shreg;
                        rx_ready <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_HI;
                  end
               end else begin
                  div_cnt <= div_cnt + 10'd1;
               end
            end

            WAIT_HI: begin
               // A break or stuck-low line must return high before a new frame.
               div_cnt <= 10'd0;
               if (rx_s) begin
                  state <= IDLE;
               end
            end

            default: begin
               state   <= IDLE;
               div_cnt <= 10'd0;
            end
         endcase
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_ready  = rx_ready;
   assign bus.frame_err = frame_err;
   assign bus.overrun   = overrun;

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart, run with a short bit period (16 clk/bit).
// A table of frames exercises data patterns, overrun and framing errors; hand
// sequences cover latency, glitch rejection, stuck-low line, read on the
// completion cycle, mid-frame reset and a loopback from a small serializer.
module tb_rx_uart;

   localparam logic [9:0] D   = 10'd15;
   localparam logic [9:0] H   = 10'd7;
   localparam int         BIT = 16;
   // Posedges from the rx falling edge to the one that raises rx_ready:
   // 2 synchroniser + (H+1) + 8 data bits + stop bit + 1.
   localparam int         LAT = 2 + (7 + 1) + 8 * (15 + 1) + (15 + 1) + 1;

   logic clk;
   logic rst;
   logic rx_drv;
   logic rd;
   logic loop_en;

   int total;
   int bad;
   int fe_cnt;
   int ov_cnt;

   rx_uart_if bus ();

   rx_uart #(
      .DIV_CNT  (D),
      .HDIV_CNT (H),
      .RX_CNT   (4'h8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Small tx serializer used for the loopback run.
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic [9:0] tx_sh;
   logic [9:0] tx_div;
   logic [3:0] tx_n;
   logic       tx_line;

   assign tx_line    = tx_busy ? tx_sh[0] : 1'b1;
   assign bus.rx     = loop_en ? tx_line : rx_drv;
   assign bus.rx_rd  = rd;

   // Serializer: start bit, 8 data bits LSB first, stop bit, D+1 clk per bit.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_busy <= 1'b0;
         tx_sh   <= '1;
         tx_div  <= '0;
         tx_n    <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            tx_sh   <= {1'b1, tx_data, 1'b0};
            tx_busy <= 1'b1;
            tx_div  <= '0;
            tx_n    <= '0;
         end
      end else if (tx_div == D) begin
         tx_div <= '0;
         tx_sh  <= {1'b1, tx_sh[9:1]};
         if (tx_n == 4'd9) tx_busy <= 1'b0;
         else              tx_n    <= tx_n + 4'd1;
      end else begin
         tx_div <= tx_div + 10'd1;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count error pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.frame_err) fe_cnt++;
      if (bus.overrun)   ov_cnt++;
   end

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       rd_after;
      logic [7:0] exp_data;
      logic       exp_ready;
      int         exp_fe;
      int         exp_ov;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rx_drv = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
   endtask

   task automatic idle(input int n);
      rx_drv = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic read_pulse();
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe0;
      int ov0;
      int waited;

      total    = 0;
      bad      = 0;
      fe_cnt   = 0;
      ov_cnt   = 0;
      rst      = 1'b1;
      rx_drv   = 1'b1;
      rd       = 1'b0;
      loop_en  = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;

      //                data   stop rd   exp_data rdy fe ov
      vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};
      vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 0, 0};
      vecs[2] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 0, 0};
      vecs[3] = '{8'h01, 1'b1, 1'b1, 8'h80, 1'b1, 0, 1};  // overrun, old byte kept
      vecs[4] = '{8'hA3, 1'b0, 1'b0, 8'h80, 1'b0, 1, 0};  // bad stop bit
      vecs[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 0, 0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rx_data",   32'(bus.rx_data),   32'h00);
      check("rst_rx_ready",  32'(bus.rx_ready),  32'h0);
      check("rst_frame_err", 32'(bus.frame_err), 32'h0);
      check("rst_overrun",   32'(bus.overrun),   32'h0);
      rst = 1'b0;
      idle(BIT);

      // 0x55 with exact latency from the rx falling edge
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      fork
         send_byte(8'h55, 1'b1);
         begin
            repeat (LAT - 1) @(posedge clk);
            @(negedge clk);
            check("lat_ready_early", 32'(bus.rx_ready), 32'h0);
            @(posedge clk);
            @(negedge clk);
            check("lat_ready_rise", 32'(bus.rx_ready), 32'h1);
         end
      join
      idle(BIT);
      check("t1_data", 32'(bus.rx_data), 32'h55);
      check("t1_fe",   32'(fe_cnt - fe0), 32'd0);
      check("t1_ov",   32'(ov_cnt - ov0), 32'd0);
      read_pulse();
      check("rd_clears_ready", 32'(bus.rx_ready), 32'h0);
      read_pulse();
      check("rd_idle_ready", 32'(bus.rx_ready), 32'h0);
      check("rd_idle_data",  32'(bus.rx_data),  32'h55);

      // Short low glitch on the line is rejected at mid start bit
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      idle(3 * BIT);
      check("glitch_ready", 32'(bus.rx_ready), 32'h0);
      check("glitch_fe",    32'(fe_cnt - fe0), 32'd0);
      check("glitch_ov",    32'(ov_cnt - ov0), 32'd0);

      // Table of frames
      for (int i = 0; i < 6; i++) begin
         fe0 = fe_cnt;
         ov0 = ov_cnt;
         send_byte(vecs[i].data, vecs[i].stop);
         idle(BIT);
         check($sformatf("vec%0d_data", i),  32'(bus.rx_data),  32'(vecs[i].exp_data));
         check($sformatf("vec%0d_ready", i), 32'(bus.rx_ready), 32'(vecs[i].exp_ready));
         check($sformatf("vec%0d_fe", i),    32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
         check($sformatf("vec%0d_ov", i),    32'(ov_cnt - ov0), 32'(vecs[i].exp_ov));
         if (vecs[i].rd_after) read_pulse();
      end

      // Framing error, line held low for three bit times, then 0x0F
      fe0 = fe_cnt;
      send_byte(8'hA3, 1'b0);
      rx_drv = 1'b0;
      repeat (3 * BIT) @(negedge clk);
      idle(2 * BIT);
      check("wait_hi_fe",    32'(fe_cnt - fe0),  32'd1);
      check("wait_hi_ready", 32'(bus.rx_ready),  32'h0);
      check("wait_hi_data",  32'(bus.rx_data),   32'h3C);
      send_byte(8'h0F, 1'b1);
      idle(BIT);
      check("after_wait_data",  32'(bus.rx_data),  32'h0F);
      check("after_wait_ready", 32'(bus.rx_ready), 32'h1);
      read_pulse();

      // Back-to-back 0x12, 0x34 with no read: overrun, first byte kept
      ov0 = ov_cnt;
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      idle(BIT);
      check("b2b_data",  32'(bus.rx_data),  32'h12);
      check("b2b_ready", 32'(bus.rx_ready), 32'h1);
      check("b2b_ov",    32'(ov_cnt - ov0), 32'd1);
      read_pulse();

      // 0x12, then read exactly on the 0x34 completion cycle
      ov0 = ov_cnt;
      send_byte(8'h12, 1'b1);
      fork
         send_byte(8'h34, 1'b1);
         begin
            repeat (LAT - 1) @(posedge clk);
            @(negedge clk);
            rd = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rd = 1'b0;
         end
      join
      idle(BIT);
      check("rd_same_data",  32'(bus.rx_data),  32'h34);
      check("rd_same_ready", 32'(bus.rx_ready), 32'h1);
      check("rd_same_ov",    32'(ov_cnt - ov0), 32'd0);

      // Reset in data bit 4 of 0xC6, then 0x81
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'(8'hC6 >> i));
      repeat (BIT / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_data",  32'(bus.rx_data),   32'h00);
      check("midrst_ready", 32'(bus.rx_ready),  32'h0);
      check("midrst_fe",    32'(bus.frame_err), 32'h0);
      check("midrst_ov",    32'(bus.overrun),   32'h0);
      rx_drv = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      idle(2 * BIT);
      check("post_rst_ready", 32'(bus.rx_ready), 32'h0);
      send_byte(8'h81, 1'b1);
      idle(BIT);
      check("post_rst_data",  32'(bus.rx_data),  32'h81);
      check("post_rst_ready2", 32'(bus.rx_ready), 32'h1);
      check("post_rst_fe",    32'(fe_cnt - fe0), 32'd0);
      check("post_rst_ov",    32'(ov_cnt - ov0), 32'd0);
      read_pulse();

      // Loopback from the serializer
      fe0 = fe_cnt;
      loop_en = 1'b1;
      tx_data = 8'hA3;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      waited = 0;
      while (!bus.rx_ready && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      check("loop_ready", 32'(bus.rx_ready), 32'h1);
      check("loop_data",  32'(bus.rx_data),  32'hA3);
      check("loop_fe",    32'(fe_cnt - fe0), 32'd0);
      idle(2 * BIT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
